// File: rtl/lif_layer_scheduler_pkg.sv
// Shared types and constants for the time-multiplexed LIF layer scheduler.
package lif_pkg;

  localparam int unsigned LIF_WIDTH      = 16;
  localparam int unsigned LIF_FRAC_WIDTH = 8;

  typedef logic signed [LIF_WIDTH-1:0]   state_t;
  typedef logic signed [2*LIF_WIDTH-1:0] mult_t;
  typedef logic signed [2*LIF_WIDTH+1:0] accum_t;

  localparam accum_t MAX_VAL = accum_t'((1 << (LIF_WIDTH - 1)) - 1);
  localparam accum_t MIN_VAL = accum_t'(-(1 << (LIF_WIDTH - 1)));

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_UPDATE,
    S_EMIT,
    S_DONE
  } fsm_state_e;

endpackage

// File: rtl/lif_layer_scheduler_if.sv
// Current-fetch and spike-event handshakes between the scheduler and its neighbours.
interface lif_layer_scheduler_if #(
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned I_WIDTH = 8
);
  logic                      cur_req;
  logic [IDX_W-1:0]          cur_idx;
  logic                      cur_valid;
  logic signed [I_WIDTH-1:0] cur_data;
  logic                      spk_valid;
  logic [IDX_W-1:0]          spk_idx;
  logic                      spk_ready;

  modport master (
    output cur_req, cur_idx,
    input  cur_valid, cur_data,
    output spk_valid, spk_idx,
    input  spk_ready
  );

  modport slave (
    input  cur_req, cur_idx,
    output cur_valid, cur_data,
    input  spk_valid, spk_idx,
    output spk_ready
  );
endinterface

// File: rtl/lif_layer_scheduler_core.sv
// Combinational single-neuron LIF update: decay, weighted input, saturate, spike.
module lif_update_core #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned FRAC_WIDTH   = 8,
  parameter int unsigned I_WIDTH      = 8,
  parameter int unsigned I_FRAC_WIDTH = 4,
  parameter int          A_OPT        = 232,
  parameter int          B_OPT        = 256,
  parameter int          V_RESET      = -20480
) (
  input  logic signed [WIDTH-1:0]   v,
  input  logic signed [I_WIDTH-1:0] i_cur,
  output logic signed [WIDTH-1:0]   v_next,
  output logic                      spike
);
  localparam int unsigned MW   = 2 * WIDTH;
  localparam int unsigned AW   = 2 * WIDTH + 2;
  localparam int          HALF = 1 << (WIDTH - 1);

  localparam logic signed [MW-1:0]    A_M   = MW'(A_OPT);
  localparam logic signed [MW-1:0]    B_M   = MW'(B_OPT);
  localparam logic signed [AW-1:0]    HI    = AW'(HALF - 1);
  localparam logic signed [AW-1:0]    LO    = AW'(-HALF);
  localparam logic signed [WIDTH-1:0] V_RST = WIDTH'(V_RESET);

  logic signed [MW-1:0] v_ext;
  logic signed [MW-1:0] i_ext;
  logic signed [MW-1:0] prod_decay;
  logic signed [MW-1:0] prod_input;
  logic signed [MW-1:0] term_decay;
  logic signed [MW-1:0] term_input;
  logic signed [AW-1:0] pre;

  // Fixed-point update with arithmetic (floor) shifts, then clamp/spike decision.
  always_comb begin
    v_ext      = {{(MW - WIDTH){v[WIDTH-1]}}, v};
    i_ext      = {{(MW - I_WIDTH){i_cur[I_WIDTH-1]}}, i_cur};
    prod_decay = v_ext * A_M;
    prod_input = B_M * i_ext;
    term_decay = prod_decay >>> FRAC_WIDTH;
    term_input = prod_input >>> I_FRAC_WIDTH;
    pre        = {{2{term_decay[MW-1]}}, term_decay} + {{2{term_input[MW-1]}}, term_input};
    spike      = 1'b0;
    v_next     = pre[WIDTH-1:0];
    if (pre >= HI) begin
      spike  = 1'b1;
      v_next = V_RST;
    end else if (pre <= LO) begin
      v_next = LO[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/lif_layer_scheduler.sv
// One LIF layer: per-timestep sweep over N_NEURONS voltages with one shared update core.
module lif_layer_scheduler
  import lif_pkg::*;
#(
  parameter int unsigned N_NEURONS    = 16,
  parameter int unsigned I_WIDTH      = 8,
  parameter int unsigned I_FRAC_WIDTH = 4,
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned FRAC_WIDTH   = 8,
  parameter int          A_OPT        = 232,
  parameter int          B_OPT        = 256,
  parameter int          V_RESET      = -20480
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         step_start,
  input  logic                         mem_clear,
  lif_layer_scheduler_if.master        bus,
  output logic                         busy,
  output logic                         step_done,
  output logic [15:0]                  step_count
);
  localparam int unsigned IDX_W = $clog2(N_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  fsm_state_e                state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [I_WIDTH-1:0] cur_q, cur_d;
  logic [IDX_W-1:0]          spk_idx_q, spk_idx_d;
  logic [15:0]               step_count_q, step_count_d;
  logic signed [WIDTH-1:0]   v_mem_q [N_NEURONS];
  logic signed [WIDTH-1:0]   v_mem_d [N_NEURONS];

  logic signed [WIDTH-1:0]   v_cur;
  logic signed [WIDTH-1:0]   v_next;
  logic                      spike;

  assign v_cur = v_mem_q[idx_q];

  lif_update_core #(
    .WIDTH        (WIDTH),
    .FRAC_WIDTH   (FRAC_WIDTH),
    .I_WIDTH      (I_WIDTH),
    .I_FRAC_WIDTH (I_FRAC_WIDTH),
    .A_OPT        (A_OPT),
    .B_OPT        (B_OPT),
    .V_RESET      (V_RESET)
  ) u_core (
    .v      (v_cur),
    .i_cur  (cur_q),
    .v_next (v_next),
    .spike  (spike)
  );

  // Outputs are pure decodes of registered state.
  assign bus.cur_req   = (state_q == S_FETCH);
  assign bus.cur_idx   = idx_q;
  assign bus.spk_valid = (state_q == S_EMIT);
  assign bus.spk_idx   = spk_idx_q;
  assign busy          = (state_q != S_IDLE);
  assign step_done     = (state_q == S_DONE);
  assign step_count    = step_count_q;

  // Next-state and datapath control; the counter bumps on entry to DONE so it is current during the pulse.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cur_d        = cur_q;
    spk_idx_d    = spk_idx_q;
    step_count_d = step_count_q;
    v_mem_d      = v_mem_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_clear) begin
          for (int unsigned i = 0; i < N_NEURONS; i++) v_mem_d[i] = '0;
        end else if (step_start) begin
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.cur_valid) begin
          cur_d   = bus.cur_data;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        v_mem_d[idx_q] = v_next;
        if (spike) begin
          spk_idx_d = idx_q;
          state_d   = S_EMIT;
        end else if (idx_q == LAST_IDX) begin
          step_count_d = step_count_q + 16'd1;
          state_d      = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EMIT: begin
        if (bus.spk_ready) begin
          if (idx_q == LAST_IDX) begin
            step_count_d = step_count_q + 16'd1;
            state_d      = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, index, latched current, spike index, counter and voltage register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cur_q        <= '0;
      spk_idx_q    <= '0;
      step_count_q <= '0;
      for (int unsigned i = 0; i < N_NEURONS; i++) v_mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cur_q        <= cur_d;
      spk_idx_q    <= spk_idx_d;
      step_count_q <= step_count_d;
      v_mem_q      <= v_mem_d;
    end
  end

endmodule

// File: tb/tb_lif_layer_scheduler.sv
// Directed bench for lif_layer_scheduler: two instances (default decay, unity decay).
module tb_lif_layer_scheduler;
  import lif_pkg::*;

  localparam int N = 16;

  logic clk;
  logic rst_n;
  logic step_start [2];
  logic mem_clear  [2];
  logic cur_valid  [2];
  logic signed [7:0] cur_data [2];
  logic spk_ready  [2];

  logic        cur_req_o    [2];
  logic [3:0]  cur_idx_o    [2];
  logic        spk_valid_o  [2];
  logic [3:0]  spk_idx_o    [2];
  logic        busy_o       [2];
  logic        step_done_o  [2];
  logic [15:0] step_count_o [2];

  int checks = 0;
  int errors = 0;

  longint mv [2][N];
  longint a_coef [2];
  logic [15:0] count [2];
  int sb [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lif_layer_scheduler_if #(.IDX_W(4), .I_WIDTH(8)) bus0 ();
  lif_layer_scheduler_if #(.IDX_W(4), .I_WIDTH(8)) bus1 ();

  assign bus0.cur_valid = cur_valid[0];
  assign bus0.cur_data  = cur_data[0];
  assign bus0.spk_ready = spk_ready[0];
  assign bus1.cur_valid = cur_valid[1];
  assign bus1.cur_data  = cur_data[1];
  assign bus1.spk_ready = spk_ready[1];
  assign cur_req_o[0]   = bus0.cur_req;
  assign cur_idx_o[0]   = bus0.cur_idx;
  assign spk_valid_o[0] = bus0.spk_valid;
  assign spk_idx_o[0]   = bus0.spk_idx;
  assign cur_req_o[1]   = bus1.cur_req;
  assign cur_idx_o[1]   = bus1.cur_idx;
  assign spk_valid_o[1] = bus1.spk_valid;
  assign spk_idx_o[1]   = bus1.spk_idx;

  lif_layer_scheduler dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_start (step_start[0]),
    .mem_clear  (mem_clear[0]),
    .bus        (bus0),
    .busy       (busy_o[0]),
    .step_done  (step_done_o[0]),
    .step_count (step_count_o[0])
  );

  lif_layer_scheduler #(.A_OPT(256)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_start (step_start[1]),
    .mem_clear  (mem_clear[1]),
    .bus        (bus1),
    .busy       (busy_o[1]),
    .step_done  (step_done_o[1]),
    .step_count (step_count_o[1])
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [15:0] peek_v(input int s, input int i);
    if (s == 0) return dut_a.v_mem_q[i];
    return dut_b.v_mem_q[i];
  endfunction

  // Reference neuron in plain integer arithmetic (B = 256, V_RESET = -20480).
  function automatic void lif_ref(input longint v, input longint i, input longint a,
                                  output bit sp, output longint vn);
    longint pre;
    pre = ((v * a) >>> 8) + ((256 * i) >>> 4);
    sp = 1'b0;
    if (pre >= 32767) begin
      sp = 1'b1;
      vn = -20480;
    end else if (pre <= -32768) begin
      vn = -32768;
    end else begin
      vn = pre;
    end
  endfunction

  task automatic check_vmem(input int s);
    for (int i = 0; i < N; i++)
      check($sformatf("v_mem[%0d]_dut%0d", i, s), peek_v(s, i), mv[s][i]);
  endtask

  task automatic zero_model(input int s);
    for (int i = 0; i < N; i++) mv[s][i] = 0;
  endtask

  task automatic check_reset(input int s);
    check("rst_cur_req", cur_req_o[s], 0);
    check("rst_cur_idx", cur_idx_o[s], 0);
    check("rst_spk_valid", spk_valid_o[s], 0);
    check("rst_spk_idx", spk_idx_o[s], 0);
    check("rst_busy", busy_o[s], 0);
    check("rst_step_done", step_done_o[s], 0);
    check("rst_step_count", step_count_o[s], 0);
    check_vmem(s);
  endtask

  // One full timestep with constant current; optional cur_valid stall, spike backpressure, mid-step poke.
  task automatic run_step(input int s, input int ival, input int stall_n, input int stall_cyc,
                          input int bp_cyc, input int poke_at);
    int n, cyc, pushed, stall_left, bp_left;
    bit sp;
    longint vn;
    step_start[s] = 1'b1;
    @(negedge clk);
    step_start[s] = 1'b0;
    check("start_cur_req", cur_req_o[s], 1);
    check("start_busy", busy_o[s], 1);
    n = 0; cyc = 0; pushed = 0; stall_left = stall_cyc; bp_left = bp_cyc;
    while (!step_done_o[s] && cyc < 2000) begin
      cur_valid[s] = 1'b0;
      spk_ready[s] = 1'b1;
      step_start[s] = (cyc == poke_at);
      mem_clear[s]  = (cyc == poke_at);
      if (cur_req_o[s]) begin
        check("cur_idx", cur_idx_o[s], n);
        if (n == stall_n && stall_left > 0) begin
          stall_left--;
        end else begin
          cur_valid[s] = 1'b1;
          cur_data[s]  = 8'(ival);
          lif_ref(mv[s][n], ival, a_coef[s], sp, vn);
          mv[s][n] = vn;
          if (sp) begin
            sb.push_back(n);
            pushed++;
          end
          n++;
        end
      end
      if (spk_valid_o[s]) begin
        check("emit_cur_req", cur_req_o[s], 0);
        if (sb.size() == 0) begin
          check("spk_unexpected", spk_valid_o[s], 0);
        end else if (bp_left > 0) begin
          check("spk_idx_hold", spk_idx_o[s], sb[0]);
          spk_ready[s] = 1'b0;
          bp_left--;
        end else begin
          check("spk_idx", spk_idx_o[s], sb.pop_front());
        end
      end
      @(negedge clk);
      cyc++;
    end
    step_start[s] = 1'b0;
    mem_clear[s]  = 1'b0;
    cur_valid[s]  = 1'b0;
    spk_ready[s]  = 1'b1;
    check("step_done_seen", step_done_o[s], 1);
    check("step_cycles", cyc, 2 * N + pushed + stall_cyc + (bp_cyc - bp_left));
    check("sb_empty", sb.size(), 0);
    sb.delete();
    count[s] = count[s] + 16'd1;
    check("step_count", step_count_o[s], count[s]);
    @(negedge clk);
    check("done_pulse_end", step_done_o[s], 0);
    check("idle_busy", busy_o[s], 0);
    check_vmem(s);
  endtask

  task automatic do_clear(input int s);
    mem_clear[s] = 1'b1;
    @(negedge clk);
    mem_clear[s] = 1'b0;
    zero_model(s);
    check("clear_busy", busy_o[s], 0);
    check_vmem(s);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      step_start[s] = 1'b0;
      mem_clear[s]  = 1'b0;
      cur_valid[s]  = 1'b0;
      cur_data[s]   = '0;
      spk_ready[s]  = 1'b1;
      count[s]      = '0;
      zero_model(s);
    end
    a_coef[0] = 232;
    a_coef[1] = 256;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset(0);
    check_reset(1);

    // Decay with default coefficients
    run_step(0, 16, -1, 0, 0, -1);
    check("v0_after_I16", peek_v(0, 0), 256);
    run_step(0, 0, -1, 0, 0, -1);
    check("v0_decay1", peek_v(0, 0), 232);
    run_step(0, 0, -1, 0, 0, -1);
    check("v0_decay2", peek_v(0, 0), 210);

    // cur_valid stall on neuron 7 plus step_start/mem_clear while busy
    run_step(0, -1, 7, 3, 0, 4);

    // mem_clear with step_start in IDLE: clear wins, no step
    step_start[0] = 1'b1;
    mem_clear[0]  = 1'b1;
    @(negedge clk);
    step_start[0] = 1'b0;
    mem_clear[0]  = 1'b0;
    zero_model(0);
    check("conflict_busy", busy_o[0], 0);
    check("conflict_cur_req", cur_req_o[0], 0);
    repeat (2) @(negedge clk);
    check("conflict_busy_later", busy_o[0], 0);
    check("conflict_count", step_count_o[0], count[0]);
    check_vmem(0);

    // Negative decay floors toward minus infinity
    run_step(0, -1, -1, 0, 0, -1);
    check("neg_small", peek_v(0, 3), -16);
    run_step(0, 0, -1, 0, 0, -1);
    check("neg_floor", peek_v(0, 3), -15);

    // Negative saturation with unity decay
    for (int t = 0; t < 17; t++) run_step(1, -128, -1, 0, 0, -1);
    check("neg_sat", peek_v(1, 15), -32768);
    do_clear(1);

    // Accumulate to threshold, then spike step with 5 cycles of backpressure
    for (int t = 0; t < 16; t++) run_step(1, 127, -1, 0, 0, -1);
    check("pre_spike_v", peek_v(1, 5), 32512);
    run_step(1, 127, -1, 0, 5, -1);
    check("post_spike_v0", peek_v(1, 0), -20480);
    check("post_spike_v15", peek_v(1, 15), -20480);

    // Reset while a spike is pending
    do_clear(1);
    for (int t = 0; t < 16; t++) run_step(1, 127, -1, 0, 0, -1);
    step_start[1] = 1'b1;
    @(negedge clk);
    step_start[1] = 1'b0;
    spk_ready[1]  = 1'b0;
    k = 0;
    while (!spk_valid_o[1] && k < 100) begin
      cur_valid[1] = cur_req_o[1];
      cur_data[1]  = 8'sd127;
      @(negedge clk);
      k++;
    end
    cur_valid[1] = 1'b0;
    check("emit_reached", spk_valid_o[1], 1);
    check("emit_idx", spk_idx_o[1], 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_spk_valid", spk_valid_o[1], 0);
    check("midrst_busy", busy_o[1], 0);
    check("midrst_cur_req", cur_req_o[1], 0);
    check("midrst_count", step_count_o[1], 0);
    zero_model(0);
    zero_model(1);
    count[0] = '0;
    count[1] = '0;
    check_vmem(1);
    check_vmem(0);
    @(negedge clk);
    rst_n = 1'b1;
    spk_ready[1] = 1'b1;
    @(negedge clk);

    // Step counter wrap, preset near the top to stay within the cycle budget
    force dut_a.step_count_q = 16'hFFFE;
    @(negedge clk);
    release dut_a.step_count_q;
    count[0] = 16'hFFFE;
    @(negedge clk);
    run_step(0, 0, -1, 0, 0, -1);
    run_step(0, 0, -1, 0, 0, -1);
    check("count_wrapped", step_count_o[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
